// File: rtl/rv32im_csr_file_rmw.sv
// rv32im_csr_file_rmw: machine-mode CSR file with RW/RS/RC access,
// 64-bit cycle/instret/hpm counters and trap entry/return.
module rv32im_csr_file_rmw #(
    parameter int                  API_XLEN  = 32,
    parameter int                  HPM_COUNT = 4,
    parameter logic [API_XLEN-1:0] MTVEC_RST = '0
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [1:0]          csr_op_i,
    input  logic [API_XLEN-1:0] csr_wdata_i,
    output logic [API_XLEN-1:0] csr_rdata_o,
    output logic                csr_illegal_o,
    input  logic                instret_i,
    input  logic [((HPM_COUNT > 0) ? HPM_COUNT : 1)-1:0] hpm_event_i,
    input  logic                trap_i,
    input  logic [API_XLEN-1:0] trap_cause_i,
    input  logic [API_XLEN-1:0] trap_pc_i,
    input  logic [API_XLEN-1:0] trap_val_i,
    input  logic                mret_i,
    output logic [API_XLEN-1:0] mtvec_o,
    output logic [API_XLEN-1:0] mepc_o,
    output logic [API_XLEN-1:0] csr_status_o,
    output logic [1:0]          priviledge_mode_o
);

    // Counter slot k lives at B00+k / B80+k: 0 cycle, 2 instret, 3.. hpm
    localparam logic [31:0] CNT_MASK =
        32'h5 | (((32'h1 << HPM_COUNT) - 32'h1) << 3);
    localparam logic [API_XLEN-1:0] MISA = API_XLEN'(32'h4000_1100);
    localparam logic [API_XLEN-1:0] W_ALIGN = {{(API_XLEN-2){1'b1}}, 2'b00};

    logic [63:0]         r_cnt [32];
    logic [63:0]         w_cnt_nxt [32];
    logic                r_ms_mie;
    logic                r_ms_mpie;
    logic [1:0]          r_ms_mpp;
    logic [1:0]          r_mode;
    logic [API_XLEN-1:0] r_mie;
    logic [API_XLEN-1:0] r_mtvec;
    logic [API_XLEN-1:0] r_mscratch;
    logic [API_XLEN-1:0] r_mepc;
    logic [API_XLEN-1:0] r_mcause;
    logic [API_XLEN-1:0] r_mtval;

    logic [API_XLEN-1:0] w_mstatus;
    logic [API_XLEN-1:0] w_old;
    logic [API_XLEN-1:0] w_new;
    logic                w_impl;
    logic                w_ro;
    logic                w_cnt;
    logic                w_cnt_wr;
    logic                w_is_wr;
    logic                w_wr;
    logic [4:0]          w_cidx;
    logic                w_chi;
    logic [31:0]         w_half;
    logic [31:0]         w_hpm;
    logic [31:0]         w_inc;

    always_comb begin
        w_mstatus = '0;
        w_mstatus[3] = r_ms_mie;
        w_mstatus[7] = r_ms_mpie;
        w_mstatus[12:11] = r_ms_mpp;
    end

    assign w_cidx = csr_addr_i[4:0];
    assign w_chi  = csr_addr_i[7];
    assign w_cnt  = (csr_addr_i[11:8] == 4'hB || csr_addr_i[11:8] == 4'hC)
                  && csr_addr_i[6:5] == 2'b00 && CNT_MASK[w_cidx];
    assign w_half = w_chi ? r_cnt[w_cidx][63:32] : r_cnt[w_cidx][31:0];

    always_comb begin
        w_impl = 1'b1;
        w_ro   = 1'b0;
        w_old  = '0;
        case (csr_addr_i)
            12'h300: w_old = w_mstatus;
            12'h301: begin
                w_old = MISA;
                w_ro  = 1'b1;
            end
            12'h304: w_old = r_mie;
            12'h305: w_old = r_mtvec;
            12'h340: w_old = r_mscratch;
            12'h341: w_old = r_mepc;
            12'h342: w_old = r_mcause;
            12'h343: w_old = r_mtval;
            12'h344: w_ro = 1'b1;
            12'hF14: w_ro = 1'b1;
            default: begin
                w_impl = w_cnt;
                w_old  = w_cnt ? API_XLEN'(w_half) : '0;
            end
        endcase
    end

    // RS/RC with a zero mask are pure reads
    assign w_is_wr = csr_op_i != 2'b00
                   && !(csr_op_i[1] && csr_wdata_i == '0);

    assign csr_illegal_o = csr_op_i != 2'b00 && (!w_impl
        || (w_is_wr && (csr_addr_i[11:10] == 2'b11 || w_ro))
        || (r_mode != 2'b11 && csr_addr_i[9:8] == 2'b11));

    assign w_wr     = w_is_wr && !csr_illegal_o;
    assign w_cnt_wr = w_wr && w_cnt;

    always_comb begin
        w_new = csr_wdata_i;
        case (csr_op_i)
            2'b10:   w_new = w_old | csr_wdata_i;
            2'b11:   w_new = w_old & ~csr_wdata_i;
            default: w_new = csr_wdata_i;
        endcase
    end

    assign w_hpm = 32'(hpm_event_i);
    assign w_inc = ((w_hpm << 3) | {29'b0, instret_i, 2'b01}) & CNT_MASK;

    // A written half drops the carry between halves for that cycle
    always_comb begin
        for (int k = 0; k < 32; k++) begin
            w_cnt_nxt[k] = r_cnt[k] + 64'(w_inc[k]);
            if (w_cnt_wr && w_cidx == 5'(k)) begin
                if (w_chi)
                    w_cnt_nxt[k] = {w_new[31:0],
                                    r_cnt[k][31:0] + 32'(w_inc[k])};
                else
                    w_cnt_nxt[k] = {r_cnt[k][63:32], w_new[31:0]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt      <= '{default: '0};
            r_ms_mie   <= 1'b0;
            r_ms_mpie  <= 1'b0;
            r_ms_mpp   <= 2'b00;
            r_mode     <= 2'b11;
            r_mie      <= '0;
            r_mtvec    <= MTVEC_RST & W_ALIGN;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_wr) begin
                case (csr_addr_i)
                    12'h304: r_mie      <= w_new;
                    12'h305: r_mtvec    <= w_new & W_ALIGN;
                    12'h340: r_mscratch <= w_new;
                    default: ;
                endcase
            end
            if (trap_i) begin
                r_mepc    <= trap_pc_i & W_ALIGN;
                r_mcause  <= trap_cause_i;
                r_mtval   <= trap_val_i;
                r_ms_mpie <= r_ms_mie;
                r_ms_mie  <= 1'b0;
                r_ms_mpp  <= r_mode;
                r_mode    <= 2'b11;
            end else if (mret_i) begin
                r_ms_mie  <= r_ms_mpie;
                r_ms_mpie <= 1'b1;
                r_mode    <= r_ms_mpp;
                r_ms_mpp  <= 2'b00;
            end else if (w_wr) begin
                case (csr_addr_i)
                    12'h300: begin
                        r_ms_mie  <= w_new[3];
                        r_ms_mpie <= w_new[7];
                        r_ms_mpp  <= (w_new[12:11] == 2'b11) ? 2'b11 : 2'b00;
                    end
                    12'h341: r_mepc   <= w_new & W_ALIGN;
                    12'h342: r_mcause <= w_new;
                    12'h343: r_mtval  <= w_new;
                    default: ;
                endcase
            end
        end
    end

    assign csr_rdata_o       = w_old;
    assign mtvec_o           = r_mtvec;
    assign mepc_o            = r_mepc;
    assign csr_status_o      = w_mstatus;
    assign priviledge_mode_o = r_mode;

endmodule

// File: tb/tb_rv32im_csr_file_rmw.sv
// Bench for rv32im_csr_file_rmw: random CSR traffic against a behavioural
// model, plus literal pins taken from the directed scenarios.
`timescale 1ns/1ps
module tb_rv32im_csr_file_rmw;
    localparam int HPM = 4;
    localparam logic [11:0] POOL [26] = '{
        12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
        12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03,
        12'hB06, 12'hB83, 12'hB86, 12'hB07, 12'hB01, 12'hC00, 12'hC80,
        12'hC02, 12'hC86, 12'hF14, 12'h7C0, 12'hB20};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] addr = '0;
    logic [1:0]  op = '0;
    logic [31:0] wdata = '0;
    logic        instret = 1'b0;
    logic [HPM-1:0] hpm_ev = '0;
    logic        trap = 1'b0;
    logic [31:0] t_cause = '0;
    logic [31:0] t_pc = '0;
    logic [31:0] t_val = '0;
    logic        mret = 1'b0;
    logic [31:0] rdata;
    logic        illegal;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic [31:0] status_o;
    logic [1:0]  mode_o;

    int n_chk = 0;
    int n_fail = 0;
    int pin_sel = 0;
    logic [31:0] pin_exp = '0;
    string pin_name = "";

    logic [63:0] m_cyc, m_ins;
    logic [63:0] m_hpm [HPM];
    logic        m_mie_b, m_mpie_b;
    logic [1:0]  m_mpp, m_mode;
    logic [31:0] m_mie, m_mtvec, m_mscr, m_mepc, m_mcause, m_mtval;

    rv32im_csr_file_rmw #(
        .API_XLEN (32),
        .HPM_COUNT(HPM),
        .MTVEC_RST(32'h0000_0103)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .csr_addr_i       (addr),
        .csr_op_i         (op),
        .csr_wdata_i      (wdata),
        .csr_rdata_o      (rdata),
        .csr_illegal_o    (illegal),
        .instret_i        (instret),
        .hpm_event_i      (hpm_ev),
        .trap_i           (trap),
        .trap_cause_i     (t_cause),
        .trap_pc_i        (t_pc),
        .trap_val_i       (t_val),
        .mret_i           (mret),
        .mtvec_o          (mtvec_o),
        .mepc_o           (mepc_o),
        .csr_status_o     (status_o),
        .priviledge_mode_o(mode_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_status();
        return {19'd0, m_mpp, 3'd0, m_mpie_b, 3'd0, m_mie_b, 3'd0};
    endfunction

    function automatic logic [63:0] m_counter(input int k);
        if (k == 0) return m_cyc;
        if (k == 2) return m_ins;
        if (k >= 3 && k < 3 + HPM) return m_hpm[k-3];
        return 64'd0;
    endfunction

    function automatic bit m_is_cnt(input logic [11:0] a);
        int k;
        k = int'(a[4:0]);
        if (a[11:8] != 4'hB && a[11:8] != 4'hC) return 1'b0;
        if (a[6:5] != 2'b00) return 1'b0;
        return k == 0 || k == 2 || (k >= 3 && k < 3 + HPM);
    endfunction

    function automatic bit m_impl(input logic [11:0] a);
        if (a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
                      12'h341, 12'h342, 12'h343, 12'h344, 12'hF14})
            return 1'b1;
        return m_is_cnt(a);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        logic [63:0] v;
        case (a)
            12'h300: return m_status();
            12'h301: return 32'h4000_1100;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscr;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            default: begin
                if (!m_is_cnt(a)) return 32'd0;
                v = m_counter(int'(a[4:0]));
                return a[7] ? v[63:32] : v[31:0];
            end
        endcase
    endfunction

    function automatic bit m_legal(input logic [11:0] a,
                                   input logic [1:0] o,
                                   input logic [31:0] w);
        bit wr;
        if (o == 2'b00) return 1'b1;
        wr = !(o[1] && w == 32'd0);
        if (!m_impl(a)) return 1'b0;
        if (wr && (a[11:10] == 2'b11 || a == 12'h301 || a == 12'h344))
            return 1'b0;
        if (m_mode != 2'b11 && a[9:8] == 2'b11) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_reset();
        m_cyc = '0;
        m_ins = '0;
        for (int i = 0; i < HPM; i++) m_hpm[i] = '0;
        m_mie_b = 1'b0;
        m_mpie_b = 1'b0;
        m_mpp = 2'b00;
        m_mode = 2'b11;
        m_mie = '0;
        m_mtvec = 32'h0000_0100;
        m_mscr = '0;
        m_mepc = '0;
        m_mcause = '0;
        m_mtval = '0;
    endtask

    task automatic m_step();
        logic [31:0] old, nv;
        logic [63:0] n_cyc, n_ins, v;
        logic [63:0] n_hpm [HPM];
        logic [31:0] inc;
        bit wr;
        int k;
        old = m_read(addr);
        wr = op != 2'b00 && !(op[1] && wdata == 32'd0)
             && m_legal(addr, op, wdata);
        case (op)
            2'b01:   nv = wdata;
            2'b10:   nv = old | wdata;
            default: nv = old & ~wdata;
        endcase
        n_cyc = m_cyc + 64'd1;
        n_ins = m_ins + 64'(instret);
        for (int i = 0; i < HPM; i++) n_hpm[i] = m_hpm[i] + 64'(hpm_ev[i]);
        if (wr && m_is_cnt(addr)) begin
            k = int'(addr[4:0]);
            v = m_counter(k);
            if (k == 0) inc = 1;
            else if (k == 2) inc = 32'(instret);
            else inc = 32'(hpm_ev[k-3]);
            if (addr[7]) v = {nv, v[31:0] + inc};
            else v = {v[63:32], nv};
            if (k == 0) n_cyc = v;
            else if (k == 2) n_ins = v;
            else n_hpm[k-3] = v;
        end
        if (wr) begin
            case (addr)
                12'h304: m_mie = nv;
                12'h305: m_mtvec = nv & 32'hFFFF_FFFC;
                12'h340: m_mscr = nv;
                default: ;
            endcase
        end
        if (trap) begin
            m_mepc = t_pc & 32'hFFFF_FFFC;
            m_mcause = t_cause;
            m_mtval = t_val;
            m_mpie_b = m_mie_b;
            m_mie_b = 1'b0;
            m_mpp = m_mode;
            m_mode = 2'b11;
        end else if (mret) begin
            m_mie_b = m_mpie_b;
            m_mpie_b = 1'b1;
            m_mode = m_mpp;
            m_mpp = 2'b00;
        end else if (wr) begin
            case (addr)
                12'h300: begin
                    m_mie_b = nv[3];
                    m_mpie_b = nv[7];
                    m_mpp = (nv[12:11] == 2'b11) ? 2'b11 : 2'b00;
                end
                12'h341: m_mepc = nv & 32'hFFFF_FFFC;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                default: ;
            endcase
        end
        m_cyc = n_cyc;
        m_ins = n_ins;
        for (int i = 0; i < HPM; i++) m_hpm[i] = n_hpm[i];
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) m_reset();
        else m_step();
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        chk("rdata", rdata, m_read(addr));
        chk("illegal", 32'(illegal), 32'(!m_legal(addr, op, wdata)));
        chk("mtvec_o", mtvec_o, m_mtvec);
        chk("mepc_o", mepc_o, m_mepc);
        chk("status_o", status_o, m_status());
        chk("mode_o", 32'(mode_o), 32'(m_mode));
        case (pin_sel)
            1: chk(pin_name, rdata, pin_exp);
            2: chk(pin_name, 32'(illegal), pin_exp);
            3: chk(pin_name, status_o, pin_exp);
            4: chk(pin_name, 32'(mode_o), pin_exp);
            5: chk(pin_name, mtvec_o, pin_exp);
            default: ;
        endcase
    end

    task automatic drive(input logic [11:0] a, input logic [1:0] o,
                         input logic [31:0] w);
        @(posedge clk);
        #1;
        addr = a;
        op = o;
        wdata = w;
        trap = 1'b0;
        mret = 1'b0;
        instret = 1'b0;
        hpm_ev = '0;
        pin_sel = 0;
    endtask

    task automatic pin(input int s, input logic [31:0] e, input string n);
        pin_sel = s;
        pin_exp = e;
        pin_name = n;
    endtask

    logic [31:0] rw;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        addr = 12'hB00;
        pin(1, 32'h0, "mcycle_first");
        drive(12'hB00, 2'b00, 0); pin(1, 32'h1, "mcycle_second");
        drive(12'h305, 2'b00, 0); pin(5, 32'h100, "mtvec_rst");
        drive(12'h300, 2'b10, 32'h88);
        drive(12'h300, 2'b00, 0); pin(1, 32'h88, "mstatus_rs");
        drive(12'h300, 2'b11, 32'h08);
        drive(12'h300, 2'b00, 0); pin(1, 32'h80, "mstatus_rc");
        drive(12'hB80, 2'b01, 32'h0);
        drive(12'hB00, 2'b01, 32'hFFFF_FFFF);
        drive(12'hB00, 2'b00, 0); pin(1, 32'hFFFF_FFFF, "mcycle_set");
        drive(12'hB80, 2'b00, 0); pin(1, 32'h1, "mcycleh_carry");
        drive(12'hB00, 2'b00, 0); pin(1, 32'h1, "mcycle_wrap");
        drive(12'h300, 2'b01, 32'h8);
        drive(12'h000, 2'b00, 0);
        trap = 1'b1; t_pc = 32'h104; t_cause = 32'hB; t_val = 32'h55;
        drive(12'h341, 2'b00, 0); pin(1, 32'h104, "mepc_trap");
        drive(12'h342, 2'b00, 0); pin(1, 32'hB, "mcause_trap");
        drive(12'h000, 2'b00, 0); pin(3, 32'h1880, "status_trap");
        mret = 1'b1;
        drive(12'h300, 2'b00, 0); pin(3, 32'h88, "status_mret");
        drive(12'h300, 2'b00, 0); pin(4, 32'h3, "mode_mret");
        drive(12'h301, 2'b01, 32'h1234); pin(2, 32'h1, "misa_wr_ill");
        drive(12'h301, 2'b00, 0); pin(1, 32'h4000_1100, "misa_kept");
        drive(12'h7C0, 2'b01, 32'h5); pin(2, 32'h1, "unimpl_ill");
        drive(12'hC00, 2'b01, 32'h7); pin(2, 32'h1, "shadow_wr_ill");
        drive(12'hC00, 2'b10, 32'h0); pin(2, 32'h0, "shadow_rs0_ok");
        drive(12'h340, 2'b01, 32'hA5A5_0001);
        drive(12'h000, 2'b00, 0);
        mret = 1'b1;
        drive(12'h000, 2'b00, 0); pin(4, 32'h0, "mode_user");
        drive(12'h340, 2'b01, 32'hDEAD_BEEF); pin(2, 32'h1, "user_ill");
        drive(12'h000, 2'b00, 0);
        trap = 1'b1; t_pc = 32'h40; t_cause = 32'h8;
        drive(12'h340, 2'b00, 0); pin(1, 32'hA5A5_0001, "mscratch_kept");
        drive(12'h341, 2'b01, 32'h200);
        trap = 1'b1; t_pc = 32'h300; t_cause = 32'h2;
        drive(12'h341, 2'b00, 0); pin(1, 32'h300, "mepc_trap_wins");
        drive(12'h340, 2'b01, 32'h1111_2222);
        rst_n = 1'b0;
        drive(12'hB00, 2'b00, 0); pin(1, 32'h0, "mcycle_after_rst");
        rst_n = 1'b1;
        drive(12'h340, 2'b00, 0); pin(1, 32'h0, "mscratch_rst");
        drive(12'h300, 2'b00, 0); pin(3, 32'h0, "status_rst");
        drive(12'h300, 2'b00, 0); pin(4, 32'h3, "mode_rst");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rw = 32'd0;
            else if ($urandom_range(0, 7) == 0)
                rw = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            else rw = $urandom;
            if ($urandom_range(0, 9) == 0)
                drive(12'($urandom), 2'($urandom), rw);
            else
                drive(POOL[$urandom_range(0, 25)], 2'($urandom), rw);
            instret = 1'($urandom);
            hpm_ev = HPM'($urandom);
            trap = ($urandom_range(0, 15) == 0);
            mret = ($urandom_range(0, 15) == 0);
            t_pc = $urandom;
            t_cause = $urandom;
            t_val = $urandom;
            rst_n = ($urandom_range(0, 299) != 0);
        end
        drive(12'h000, 2'b00, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
